// File: rtl/pipe_hold_ctrl.sv
// Stall/flush controller for IF/ID/EX: load-use bubbles, multi-cycle holds, redirects.
// Latency: hold/flush/pc_load are combinational (same edge); mc_timeout_o is registered (+1 cycle).
// Backpressure: holds freeze PC, IF/ID and ID/EX; a flush replaces the stage contents with a NOP.
module pipe_hold_ctrl #(
    parameter int LOAD_LAT   = 1,
    parameter int MC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_reg1_raddr_i,
    input  logic [4:0]  id_reg2_raddr_i,
    input  logic        id_reg1_re_i,
    input  logic        id_reg2_re_i,
    input  logic [4:0]  ex_reg_waddr_i,
    input  logic        ex_reg_we_i,
    input  logic        ex_is_load_i,
    input  logic        ex_mc_start_i,
    input  logic        ex_mc_done_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        int_assert_i,
    input  logic [31:0] int_addr_i,
    output logic        hold_pc_o,
    output logic        hold_ifid_o,
    output logic        hold_idex_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o,
    output logic        pc_load_o,
    output logic [31:0] pc_load_addr_o,
    output logic        mc_timeout_o,
    output logic [31:0] stall_cnt_o
);

    localparam int MCW = $clog2(MC_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MC_WAIT   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       bub_cnt_q, bub_cnt_d;
    logic [MCW-1:0]   mc_cnt_q, mc_cnt_d;
    logic             mc_timeout_q, mc_timeout_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic             load_use;
    logic             hold_pc, hold_ifid, hold_idex;
    logic             flush_ifid, flush_idex, pc_load;
    logic [31:0]      pc_load_addr;

    // Hazard: a load in EX writes a non-zero rd that the ID instruction reads.
    always_comb begin
        load_use = ex_is_load_i && ex_reg_we_i && (ex_reg_waddr_i != 5'd0) &&
                   ((id_reg1_re_i && (id_reg1_raddr_i == ex_reg_waddr_i)) ||
                    (id_reg2_re_i && (id_reg2_raddr_i == ex_reg_waddr_i)));
    end

    // Next-state and raw (pre-reset-gating) control outputs.
    always_comb begin
        state_d      = state_q;
        bub_cnt_d    = bub_cnt_q;
        mc_cnt_d     = mc_cnt_q;
        mc_timeout_d = 1'b0;
        hold_pc      = 1'b0;
        hold_ifid    = 1'b0;
        hold_idex    = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = 32'd0;
        case (state_q)
            RUN: begin
                if (int_assert_i) begin
                    pc_load      = 1'b1;
                    pc_load_addr = int_addr_i;
                    flush_ifid   = 1'b1;
                    flush_idex   = 1'b1;
                end else if (ex_jump_i) begin
                    // The ID instruction is flushed, so its hazards no longer matter.
                    pc_load      = 1'b1;
                    pc_load_addr = ex_jump_addr_i;
                    flush_ifid   = 1'b1;
                    flush_idex   = 1'b1;
                end else if (ex_mc_start_i) begin
                    hold_pc   = 1'b1;
                    hold_ifid = 1'b1;
                    hold_idex = 1'b1;
                    mc_cnt_d  = MCW'(1);
                    state_d   = MC_WAIT;
                end else if (load_use) begin
                    hold_pc    = 1'b1;
                    hold_ifid  = 1'b1;
                    flush_idex = 1'b1;
                    if (LOAD_LAT > 1) begin
                        bub_cnt_d = 3'(LOAD_LAT - 1);
                        state_d   = LU_BUBBLE;
                    end
                end
            end
            LU_BUBBLE: begin
                // EX holds a bubble here, so jump and multi-cycle start cannot occur.
                if (int_assert_i) begin
                    pc_load      = 1'b1;
                    pc_load_addr = int_addr_i;
                    flush_ifid   = 1'b1;
                    flush_idex   = 1'b1;
                    bub_cnt_d    = 3'd0;
                    state_d      = RUN;
                end else begin
                    hold_pc    = 1'b1;
                    hold_ifid  = 1'b1;
                    flush_idex = 1'b1;
                    if (bub_cnt_q <= 3'd1) begin
                        bub_cnt_d = 3'd0;
                        state_d   = RUN;
                    end else begin
                        bub_cnt_d = bub_cnt_q - 3'd1;
                    end
                end
            end
            MC_WAIT: begin
                if (int_assert_i) begin
                    pc_load      = 1'b1;
                    pc_load_addr = int_addr_i;
                    flush_ifid   = 1'b1;
                    flush_idex   = 1'b1;
                    mc_cnt_d     = '0;
                    state_d      = RUN;
                end else if (ex_mc_done_i) begin
                    // Done wins over a coincident timeout: no pulse.
                    mc_cnt_d = '0;
                    state_d  = RUN;
                end else if (mc_cnt_q == MCW'(MC_TIMEOUT)) begin
                    mc_timeout_d = 1'b1;
                    mc_cnt_d     = '0;
                    state_d      = RUN;
                end else begin
                    hold_pc   = 1'b1;
                    hold_ifid = 1'b1;
                    hold_idex = 1'b1;
                    mc_cnt_d  = mc_cnt_q + MCW'(1);
                end
            end
            default: begin
                state_d   = RUN;
                bub_cnt_d = 3'd0;
                mc_cnt_d  = '0;
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is asserted.
    always_comb begin
        hold_pc_o      = hold_pc    && !rst;
        hold_ifid_o    = hold_ifid  && !rst;
        hold_idex_o    = hold_idex  && !rst;
        flush_ifid_o   = flush_ifid && !rst;
        flush_idex_o   = flush_idex && !rst;
        pc_load_o      = pc_load    && !rst;
        pc_load_addr_o = rst ? 32'd0 : pc_load_addr;
    end

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hold_pc_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            bub_cnt_q    <= 3'd0;
            mc_cnt_q     <= '0;
            mc_timeout_q <= 1'b0;
            stall_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            bub_cnt_q    <= bub_cnt_d;
            mc_cnt_q     <= mc_cnt_d;
            mc_timeout_q <= mc_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign mc_timeout_o = mc_timeout_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Stall/flush controller for the IF/ID/EX pipeline.
- The EX→ID forwarding logic covers ALU results. This block covers the cases forwarding cannot:
  - load-use hazards, handled with bubble insertion;
  - multi-cycle EX ops such as the divider, handled with a full-pipeline hold;
  - control redirects (EX jump, interrupt), handled with a PC load plus flushes.
- Drives PC, IF/ID and ID/EX pipeline registers; sits beside the forwarding mux logic in the core top.

Parameters:
LOAD_LAT, 1, number of bubble cycles inserted per load-use hazard (1..7)
MC_TIMEOUT, 64, max cycles spent in MC_WAIT before forced release (2..1023)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
id_reg1_raddr_i  input  5  ID rs1 address
id_reg2_raddr_i  input  5  ID rs2 address
id_reg1_re_i  input  1  ID reads rs1
id_reg2_re_i  input  1  ID reads rs2
ex_reg_waddr_i  input  5  EX rd address
ex_reg_we_i  input  1  EX writes rd
ex_is_load_i  input  1  EX instruction is a load
ex_mc_start_i  input  1  EX begins multi-cycle op (1-cycle pulse)
ex_mc_done_i  input  1  multi-cycle result valid (1-cycle pulse)
ex_jump_i  input  1  EX takes a jump/branch
ex_jump_addr_i  input  32  jump target
int_assert_i  input  1  interrupt redirect request
int_addr_i  input  32  interrupt vector
hold_pc_o  output  1  PC holds value
hold_ifid_o  output  1  IF/ID register holds
hold_idex_o  output  1  ID/EX register holds
flush_ifid_o  output  1  IF/ID loads NOP
flush_idex_o  output  1  ID/EX loads NOP
pc_load_o  output  1  PC loads pc_load_addr_o next edge
pc_load_addr_o  output  32  redirect target
mc_timeout_o  output  1  registered 1-cycle pulse: multi-cycle op timed out
stall_cnt_o  output  32  cycles with hold_pc_o=1, saturating

Behaviour:
- Reset values and clocking:
  - rst asynchronous, active-high.
  - On reset: state=RUN, bubble counter=0, MC counter=0, mc_timeout_o=0, stall_cnt_o=0.
  - While rst=1, all combinational outputs are 0 and pc_load_addr_o=0.
- Output timing:
  - Hold, flush and pc_load outputs are combinational from state plus current inputs. They take effect at the same edge, with zero latency.
- load_use is true when all of the following hold:
  - ex_is_load_i & ex_reg_we_i & (ex_reg_waddr_i != 0);
  - and either (id_reg1_re_i & rs1 == rd) or (id_reg2_re_i & rs2 == rd).
- States: RUN, LU_BUBBLE, MC_WAIT.
- RUN, evaluated in priority order:
  1. int_assert_i: pc_load_o=1, pc_load_addr_o=int_addr_i, flush_ifid_o=1, flush_idex_o=1. All other requests are ignored. Stay in RUN.
  2. ex_jump_i: same as (1) but with ex_jump_addr_i. load_use and ex_mc_start_i are ignored, since the ID instruction is flushed.
  3. ex_mc_start_i: hold_pc_o, hold_ifid_o and hold_idex_o all =1. MC counter=1. Go to MC_WAIT.
  4. load_use: hold_pc_o=1, hold_ifid_o=1, flush_idex_o=1.
     - If LOAD_LAT>1: bubble counter=LOAD_LAT-1, go to LU_BUBBLE.
     - Otherwise stay in RUN.
  5. Otherwise all outputs are 0.
- LU_BUBBLE:
  - Outputs: hold_pc_o=1, hold_ifid_o=1, flush_idex_o=1.
  - Bubble counter decrements each cycle; when it reaches 1, next state is RUN.
  - int_assert_i overrides: redirect+flush as in RUN(1), counter cleared, go to RUN.
  - ex_jump_i and ex_mc_start_i are impossible here, because EX holds a bubble; ignore them.
- MC_WAIT:
  - Outputs: hold_pc_o, hold_ifid_o and hold_idex_o all =1. The MC counter increments.
  - ex_mc_done_i: all holds drop to 0 in that same cycle; go to RUN; counter cleared.
  - Timeout: if the counter equals MC_TIMEOUT and done is absent, holds drop to 0 that cycle. mc_timeout_o=1 in the following cycle; go to RUN.
  - Done arriving in the same cycle as the timeout is treated as done: no timeout pulse.
  - int_assert_i aborts: redirect+flush as in RUN(1), holds=0, go to RUN, counter cleared.
- stall_cnt_o:
  - Increments on each clk edge where hold_pc_o=1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by rst.
- Reset asserted mid-MC_WAIT or mid-LU_BUBBLE returns to RUN immediately, with no outputs asserted.

Test Plan:
- Load-use, LOAD_LAT=1: ex_is_load_i=1, ex_reg_we_i=1, ex_reg_waddr_i=5, id_reg1_raddr_i=5, id_reg1_re_i=1 -> 1 cycle of hold_pc/hold_ifid/flush_idex; stall_cnt_o=1. Repeat with rd=0 -> no stall. Repeat with id_reg1_re_i=0 -> no stall.
- LOAD_LAT=3, same hazard -> exactly 3 consecutive bubble cycles, then RUN; stall_cnt_o=3.
- Divide: ex_mc_start_i pulse, ex_mc_done_i 10 cycles later -> all three holds =1 for 10 cycles and low in the done cycle; stall_cnt_o=10.
- Timeout, MC_TIMEOUT=4: start with no done -> holds high 4 cycles, release, mc_timeout_o pulses 1 cycle after release.
- Same-cycle ex_jump_i=1 (addr 0x100), load_use=1, ex_mc_start_i=1 -> pc_load_o=1, addr 0x100, both flushes, no holds, state RUN. int_assert_i=1 (addr 0x80) with jump in the same cycle -> addr 0x80.
- int_assert_i in cycle 3 of MC_WAIT -> redirect to int_addr_i, flushes, holds=0, RUN. Async rst mid-LU_BUBBLE -> outputs 0 immediately, stall_cnt_o=0.
